// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX packet arbiter: FSM state encoding
// and the round-robin pointer wrap helper.
package uart_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_XFER = 2'd1;
  localparam arb_state_t ST_GAP  = 2'd2;

  // Pointer to the requester after 'cur', wrapping from n_req-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n_req);
    if (cur + 1 >= n_req) begin
      return 0;
    end
    return cur + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first asserted request at
// or after rr_ptr_i, searching cyclically, plus a flag that any request is up.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   rr_ptr_i,
  output logic [IDW-1:0]   winner_o,
  output logic             any_req_o
);

  int idx;

  // Scan offsets 0..N_REQ-1 from the pointer; the first hit is kept.
  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!any_req_o && req_i[IDW'(idx)]) begin
        any_req_o = 1'b1;
        winner_o  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UART TX byte channel.
// The grant is held for a whole packet, an idle gap follows every packet,
// and a packet whose owner stops presenting bytes is aborted on timeout.
//
// state | meaning
// IDLE  | no grant; choose a winner when any request is up
// XFER  | granted requester's bytes pass straight through to the TX core
// GAP   | enforced quiet time between packets
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [$clog2(N_REQ)-1:0]   timeout_id
);

  localparam int IDW = $clog2(N_REQ);
  // A zero-length gap still needs a legal one-bit counter.
  localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam arb_state_t    ST_AFTER = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  arb_state_t     state_q,   state_d;
  logic [IDW-1:0] rr_ptr_q,  rr_ptr_d;
  logic [IDW-1:0] grant_q,   grant_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]  to_cnt_q,  to_cnt_d;
  logic           terr_q,    terr_d;
  logic [IDW-1:0] tid_q,     tid_d;

  logic [IDW-1:0] pick_winner;
  logic           pick_any;

  logic           in_xfer;
  logic           cur_valid;
  logic           cur_last;
  logic [7:0]     cur_data;
  logic           pkt_done;
  logic           to_expire;
  logic [IDW-1:0] grant_next_ptr;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (pick_winner),
    .any_req_o (pick_any)
  );

  assign in_xfer        = (state_q == ST_XFER);
  assign cur_valid      = req_valid[grant_q];
  assign cur_last       = req_last[grant_q];
  assign cur_data       = req_data[{grant_q, 3'b000} +: 8];
  assign pkt_done       = tx_valid & tx_ready & cur_last;
  // Valid low on the cycle the count would reach TIMEOUT_CYCLES aborts now.
  assign to_expire      = in_xfer & ~cur_valid & (to_cnt_q == TO_LAST);
  assign grant_next_ptr = IDW'(rr_next(32'(grant_q), N_REQ));

  assign tx_valid    = in_xfer & cur_valid;
  assign tx_data     = in_xfer ? cur_data : 8'h00;
  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = terr_q;
  assign timeout_id  = tid_q;

  // Only the granted requester sees the TX core's ready, and only in XFER.
  always_comb begin
    req_ready = '0;
    if (in_xfer) begin
      req_ready[grant_q] = tx_ready;
    end
  end

  // FSM next state, grant/pointer updates and both counters.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    terr_d    = 1'b0;
    tid_d     = tid_q;

    case (state_q)
      ST_IDLE: begin
        gap_cnt_d = '0;
        to_cnt_d  = '0;
        if (pick_any) begin
          grant_d = pick_winner;
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        if (pkt_done) begin
          rr_ptr_d = grant_next_ptr;
          to_cnt_d = '0;
          state_d  = ST_AFTER;
        end else if (cur_valid) begin
          // A byte on offer, even if stalled by tx_ready, is not idleness.
          to_cnt_d = '0;
        end else if (to_expire) begin
          terr_d   = 1'b1;
          tid_d    = grant_q;
          rr_ptr_d = grant_next_ptr;
          to_cnt_d = '0;
          state_d  = ST_AFTER;
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        gap_cnt_d = '0;
        to_cnt_d  = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any grant at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
      terr_q    <= 1'b0;
      tid_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      terr_q    <= terr_d;
      tid_q     <= tid_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Instance A uses GAP_CYCLES=16 and
// TIMEOUT_CYCLES=10; instance B uses GAP_CYCLES=0. Both share the inputs.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_last = '0;
  logic        tx_ready = 1'b1;

  logic [2:0]  a_req_ready, b_req_ready;
  logic        a_tx_valid, b_tx_valid;
  logic [7:0]  a_tx_data, b_tx_data;
  logic [1:0]  a_grant_id, b_grant_id;
  logic        a_busy, b_busy;
  logic        a_timeout_err, b_timeout_err;
  logic [1:0]  a_timeout_id, b_timeout_id;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(3), .GAP_CYCLES(16), .TIMEOUT_CYCLES(10)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(a_req_ready), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
    .tx_ready(tx_ready), .grant_id(a_grant_id), .busy(a_busy),
    .timeout_err(a_timeout_err), .timeout_id(a_timeout_id)
  );

  uart_tx_arbiter #(.N_REQ(3), .GAP_CYCLES(0), .TIMEOUT_CYCLES(10)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(b_req_ready), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
    .tx_ready(tx_ready), .grant_id(b_grant_id), .busy(b_busy),
    .timeout_err(b_timeout_err), .timeout_id(b_timeout_id)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [23:0] d;
    logic [2:0]  l;
    logic        txr;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic [2:0]  e_rdy;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic        e_terr;
    logic [1:0]  e_tid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [2:0] v,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic [2:0] l, input logic txr,
                              input logic etv, input logic [7:0] etd, input logic [2:0] erdy,
                              input logic [1:0] egid, input logic ebusy,
                              input logic eterr, input logic [1:0] etid);
    vec_t r;
    r.rst = rst; r.v = v; r.d = {d2, d1, d0}; r.l = l; r.txr = txr;
    r.e_txv = etv; r.e_txd = etd; r.e_rdy = erdy; r.e_gid = egid;
    r.e_busy = ebusy; r.e_terr = eterr; r.e_tid = etid;
    return r;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_table(input string tname, input bit use_b);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      reset = vecs[i].rst; req_valid = vecs[i].v; req_data = vecs[i].d;
      req_last = vecs[i].l; tx_ready = vecs[i].txr;
      @(negedge clk);
      check($sformatf("%s[%0d].tx_valid", tname, i), 32'(use_b ? b_tx_valid : a_tx_valid), 32'(vecs[i].e_txv));
      check($sformatf("%s[%0d].tx_data", tname, i), 32'(use_b ? b_tx_data : a_tx_data), 32'(vecs[i].e_txd));
      check($sformatf("%s[%0d].req_ready", tname, i), 32'(use_b ? b_req_ready : a_req_ready), 32'(vecs[i].e_rdy));
      check($sformatf("%s[%0d].grant_id", tname, i), 32'(use_b ? b_grant_id : a_grant_id), 32'(vecs[i].e_gid));
      check($sformatf("%s[%0d].busy", tname, i), 32'(use_b ? b_busy : a_busy), 32'(vecs[i].e_busy));
      check($sformatf("%s[%0d].timeout_err", tname, i), 32'(use_b ? b_timeout_err : a_timeout_err), 32'(vecs[i].e_terr));
      check($sformatf("%s[%0d].timeout_id", tname, i), 32'(use_b ? b_timeout_id : a_timeout_id), 32'(vecs[i].e_tid));
    end
    vecs.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hs_cyc[$];
    logic [1:0]  hs_gid[$];
    logic [7:0]  hs_dat[$];

    // Reset values on both instances.
    do_reset();
    @(negedge clk);
    check("rst.a.tx_valid", 32'(a_tx_valid), 0);
    check("rst.a.tx_data", 32'(a_tx_data), 0);
    check("rst.a.req_ready", 32'(a_req_ready), 0);
    check("rst.a.busy", 32'(a_busy), 0);
    check("rst.a.grant_id", 32'(a_grant_id), 0);
    check("rst.a.timeout_err", 32'(a_timeout_err), 0);
    check("rst.a.timeout_id", 32'(a_timeout_id), 0);
    check("rst.b.busy", 32'(b_busy), 0);
    check("rst.b.tx_valid", 32'(b_tx_valid), 0);

    // Single requester 1: "AT\r" then a 16-cycle gap, then IDLE.
    vecs.push_back(mk(0, 3'b010, 8'h00, 8'h41, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 3'b010, 8'h00, 8'h41, 8'h00, 3'b000, 1, 1, 8'h41, 3'b010, 2'd1, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b010, 8'h00, 8'h54, 8'h00, 3'b000, 1, 1, 8'h54, 3'b010, 2'd1, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b010, 8'h00, 8'h0D, 8'h00, 3'b010, 1, 1, 8'h0D, 3'b010, 2'd1, 1, 0, 2'd0));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd1, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd1, 0, 0, 2'd0));
    do_reset();
    run_table("single", 0);

    // Backpressure: tx_ready toggles; requester 1 waits and never sees ready.
    vecs.push_back(mk(0, 3'b011, 8'h11, 8'hEE, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 3'b011, 8'h11, 8'hEE, 8'h00, 3'b000, 1, 1, 8'h11, 3'b001, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b011, 8'h22, 8'hEE, 8'h00, 3'b000, 0, 1, 8'h22, 3'b000, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b011, 8'h22, 8'hEE, 8'h00, 3'b000, 1, 1, 8'h22, 3'b001, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b011, 8'h33, 8'hEE, 8'h00, 3'b000, 0, 1, 8'h33, 3'b000, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b011, 8'h33, 8'hEE, 8'h00, 3'b000, 1, 1, 8'h33, 3'b001, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b011, 8'h44, 8'hEE, 8'h00, 3'b001, 0, 1, 8'h44, 3'b000, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b011, 8'h44, 8'hEE, 8'h00, 3'b001, 1, 1, 8'h44, 3'b001, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b010, 8'h00, 8'hEE, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd0, 1, 0, 2'd0));
    do_reset();
    run_table("backpressure", 0);

    // Timeout: req 2 sends one byte without last, then goes quiet.
    vecs.push_back(mk(0, 3'b100, 8'h00, 8'h00, 8'h77, 3'b000, 1, 0, 8'h00, 3'b000, 2'd0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 3'b100, 8'h00, 8'h00, 8'h77, 3'b000, 1, 1, 8'h77, 3'b100, 2'd2, 1, 0, 2'd0));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1, 0, 8'h00, 3'b100, 2'd2, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd2, 1, 1, 2'd2));
    for (int k = 0; k < 15; k++)
      vecs.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd2, 1, 0, 2'd2));
    vecs.push_back(mk(0, 3'b111, 8'hAA, 8'hBB, 8'hCC, 3'b000, 1, 0, 8'h00, 3'b000, 2'd2, 0, 0, 2'd2));
    vecs.push_back(mk(0, 3'b111, 8'hAA, 8'hBB, 8'hCC, 3'b000, 1, 1, 8'hAA, 3'b001, 2'd0, 1, 0, 2'd2));
    do_reset();
    run_table("timeout", 0);

    // Reset mid-packet: req 0 packet moves rr_ptr to 1, req 1 is cut off.
    vecs.push_back(mk(0, 3'b001, 8'h5A, 8'h00, 8'h00, 3'b001, 1, 0, 8'h00, 3'b000, 2'd0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 3'b001, 8'h5A, 8'h00, 8'h00, 3'b001, 1, 1, 8'h5A, 3'b001, 2'd0, 1, 0, 2'd0));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b010, 8'h00, 8'h01, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 3'b010, 8'h00, 8'h01, 8'h00, 3'b000, 1, 1, 8'h01, 3'b010, 2'd1, 1, 0, 2'd0));
    vecs.push_back(mk(1, 3'b010, 8'h00, 8'h02, 8'h00, 3'b000, 1, 1, 8'h02, 3'b010, 2'd1, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b111, 8'hAA, 8'hBB, 8'hCC, 3'b000, 1, 0, 8'h00, 3'b000, 2'd0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 3'b111, 8'hAA, 8'hBB, 8'hCC, 3'b000, 1, 1, 8'hAA, 3'b001, 2'd0, 1, 0, 2'd0));
    do_reset();
    run_table("reset_mid", 0);

    // Stalled by tx_ready low well past TIMEOUT_CYCLES with valid held: no abort.
    vecs.push_back(mk(0, 3'b001, 8'h99, 8'h00, 8'h00, 3'b000, 0, 0, 8'h00, 3'b000, 2'd0, 0, 0, 2'd0));
    for (int k = 0; k < 15; k++)
      vecs.push_back(mk(0, 3'b001, 8'h99, 8'h00, 8'h00, 3'b000, 0, 1, 8'h99, 3'b000, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b001, 8'h99, 8'h00, 8'h00, 3'b001, 1, 1, 8'h99, 3'b001, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd0, 1, 0, 2'd0));
    do_reset();
    run_table("stall", 0);

    // GAP_CYCLES=0 (instance B): one IDLE cycle between back-to-back packets.
    vecs.push_back(mk(0, 3'b011, 8'hC1, 8'hD2, 8'h00, 3'b011, 1, 0, 8'h00, 3'b000, 2'd0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 3'b011, 8'hC1, 8'hD2, 8'h00, 3'b011, 1, 1, 8'hC1, 3'b001, 2'd0, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b010, 8'h00, 8'hD2, 8'h00, 3'b010, 1, 0, 8'h00, 3'b000, 2'd0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 3'b010, 8'h00, 8'hD2, 8'h00, 3'b010, 1, 1, 8'hD2, 3'b010, 2'd1, 1, 0, 2'd0));
    vecs.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1, 0, 8'h00, 3'b000, 2'd1, 0, 0, 2'd0));
    do_reset();
    run_table("gap0", 1);

    // Round-robin: all three hold 1-byte packets; expect 0,1,2,0,1,2 every 18 cycles.
    do_reset();
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 3'b111; req_data = {8'hC2, 8'hB1, 8'hA0};
    req_last = 3'b111; tx_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (a_tx_valid && tx_ready) begin
        hs_cyc.push_back(c);
        hs_gid.push_back(a_grant_id);
        hs_dat.push_back(a_tx_data);
      end
      if (hs_cyc.size() == 6) break;
    end
    check("rr.handshake_count", 32'(hs_cyc.size()), 6);
    if (hs_cyc.size() > 0) check("rr.first_cycle", 32'(hs_cyc[0]), 1);
    for (int i = 0; i < hs_cyc.size(); i++) begin
      logic [7:0] exp_dat;
      exp_dat = 8'hA0 + 8'(17 * (i % 3));
      check($sformatf("rr[%0d].grant_id", i), 32'(hs_gid[i]), 32'(i % 3));
      check($sformatf("rr[%0d].tx_data", i), 32'(hs_dat[i]), 32'(exp_dat));
      if (i > 0) check($sformatf("rr[%0d].spacing", i), 32'(hs_cyc[i] - hs_cyc[i-1]), 18);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares one UART transmit byte channel among several requesters (camera command, cell-module AT command, and GPS configuration streams). It sits between the requester byte streams and a single UART TX core's valid/ready byte input. It locks the grant for a whole packet, inserts a configurable idle gap between packets, and aborts stalled packets with a timeout.

## Interface
Parameters:
- N_REQ, 3, number of requesters (2..8)
- GAP_CYCLES, 16, idle cycles forced between packets (0 allowed)
- TIMEOUT_CYCLES, 50000, consecutive cycles with granted req_valid low mid-packet before abort (≥1)

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  N_REQ  marks final byte of packet, qualified by req_valid
- req_ready  out  N_REQ  per-requester byte accepted
- tx_valid  out  1  byte valid to UART TX core
- tx_data  out  8  byte to UART TX core
- tx_ready  in  1  UART TX core can accept byte
- grant_id  out  $clog2(N_REQ)  currently or last granted requester
- busy  out  1  high in XFER or GAP
- timeout_err  out  1  one-cycle pulse on packet abort
- timeout_id  out  $clog2(N_REQ)  requester aborted; held until next abort

## Operation
- States: IDLE, XFER, GAP.
- IDLE: if any req_valid is high, pick the winner round-robin starting at rr_ptr, register grant_id, and go to XFER next cycle. No byte is transferred in the decision cycle.
- XFER: tx_valid = req_valid[grant_id] and tx_data = req_data[grant_id], both combinational. req_ready[grant_id] = tx_ready. All other req_ready are 0.
- A handshake (tx_valid & tx_ready) with req_last[grant_id] high ends the packet: rr_ptr becomes grant_id+1, wrapping from N_REQ-1 to 0. Go to GAP, or to IDLE if GAP_CYCLES=0.
- Timeout counter: cleared on entry to XFER and in any XFER cycle where req_valid[grant_id]=1. Otherwise it increments. On reaching TIMEOUT_CYCLES: pulse timeout_err, load timeout_id=grant_id, advance rr_ptr as for normal completion, and go to GAP or IDLE. The requester is responsible for discarding the remainder of its packet. Bytes it presents later start a new packet.
- Simultaneous last-byte handshake and timeout expiry cannot occur, because valid=1 clears the counter. If a requester holds valid while tx_ready stays low indefinitely, this is not a timeout.
- GAP: gap counter counts GAP_CYCLES cycles, then goes to IDLE. tx_valid=0 and all req_ready=0.
- A requester withdrawing req_valid in IDLE before a grant is legal and never wins.
- No grant preemption: a higher-priority request during XFER waits for the packet to end.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0
  - tx_valid=0, tx_data=0 (tx_data is 0 whenever not in XFER)
  - req_ready=0, busy=0
  - timeout_err=0, timeout_id=0
  - both counters=0
- Reset mid-packet drops the grant immediately. The partial packet is not completed.
- Latency: first byte can be presented on tx_valid 1 cycle after req_valid rises in IDLE. Bytes then flow at 1 byte/cycle when tx_ready=1.
- Packet-to-packet: the last handshake at cycle t gives GAP for cycles t+1..t+GAP_CYCLES, IDLE at t+GAP_CYCLES+1, and the next XFER at t+GAP_CYCLES+2.
- Timeout: valid low from cycle t (counter 0→1 at t) gives the abort in cycle t+TIMEOUT_CYCLES-1, with the timeout_err pulse registered in the following cycle.
- Counter widths: $clog2(GAP_CYCLES+1) and $clog2(TIMEOUT_CYCLES+1). Counters saturate and never wrap.

## Structure
- Package uart_arb_pkg holds the state enum (IDLE, XFER, GAP) and a function for next-pointer wrap.
- Sub-module rr_picker is purely combinational. Inputs: req vector, rr_ptr. Outputs: winner index and any_req. It picks the first set bit at or after rr_ptr, cyclically.
- The top holds the FSM, counters and the datapath mux.

## Test plan
- Single requester: req 1 sends a 3-byte packet 0x41,0x54,0x0D with tx_ready=1. Required: bytes appear on tx_data in consecutive cycles starting 1 cycle after req_valid; grant_id=1; busy stays high for 16 gap cycles; then IDLE.
- Round-robin: all three requesters hold 1-byte packets continuously. Required: grant order 0,1,2,0,1,2, each packet separated by GAP_CYCLES+1 non-transfer cycles.
- Backpressure: tx_ready toggles 1,0,1,0 during a 4-byte packet. Required: each byte held stable on tx_data while tx_ready=0; req_ready mirrors tx_ready only for the granted requester.
- Timeout with TIMEOUT_CYCLES=10: req 2 sends 1 byte without last, then drops valid. Required: timeout_err is a single-cycle pulse; timeout_id=2; the next grant starts at req 0.
- Reset mid-packet: assert reset during byte 2 of 5. Required: the next cycle has tx_valid=0, req_ready=0, busy=0, grant_id=0; after release, requester 0 has priority.
- GAP_CYCLES=0: two back-to-back packets from different requesters. Required: exactly one IDLE cycle between the last byte of the first and the first byte of the second.
